// File: rtl/mem_arbiter.sv
// ============================================================================
// mem_arbiter
//   Round-robin arbiter sharing one single-ported backing memory between the
//   instruction-fetch (I) and load/store (D) ports of the CPU.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module mem_arbiter #(
  parameter int MEM_LATENCY = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_valid,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_valid,
  output logic [31:0] d_rdata,
  output logic [31:0] m_addr,
  output logic [31:0] m_din,
  output logic        m_read,
  output logic        m_write,
  input  logic [31:0] m_dout
);

  localparam int CW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam logic [CW-1:0] c_cnt_init = CW'(MEM_LATENCY - 1);
  localparam logic c_src_i = 1'b0;
  localparam logic c_src_d = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic          src_q, src_d;
  logic          last_grant_q, last_grant_d;
  logic          we_q, we_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   i_rdata_q, i_rdata_d;
  logic [31:0]   d_rdata_q, d_rdata_d;
  logic          grant_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      src_q        <= c_src_i;
      last_grant_q <= c_src_i;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      cnt_q        <= '0;
      i_rdata_q    <= '0;
      d_rdata_q    <= '0;
    end else begin
      state_q      <= state_d;
      src_q        <= src_d;
      last_grant_q <= last_grant_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      cnt_q        <= cnt_d;
      i_rdata_q    <= i_rdata_d;
      d_rdata_q    <= d_rdata_d;
    end
  end

  // On a tie the port that did not win last time gets the bus.
  assign grant_d = d_req && (!i_req || (last_grant_q == c_src_i));

  always_comb begin
    state_d      = state_q;
    src_d        = src_q;
    last_grant_d = last_grant_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    cnt_d        = cnt_q;
    i_rdata_d    = i_rdata_q;
    d_rdata_d    = d_rdata_q;
    case (state_q)
      IDLE: begin
        if (i_req || d_req) begin
          state_d      = BUSY;
          src_d        = grant_d;
          last_grant_d = grant_d;
          we_d         = grant_d & d_we;
          addr_d       = grant_d ? d_addr : i_addr;
          wdata_d      = grant_d ? d_wdata : 32'h0;
          cnt_d        = c_cnt_init;
        end
      end
      BUSY: begin
        if (cnt_q == '0) begin
          state_d = DONE;
          if (!we_q) begin
            if (src_q == c_src_d) d_rdata_d = m_dout;
            else                  i_rdata_d = m_dout;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign m_addr  = addr_q;
  assign m_din   = wdata_q;
  assign m_read  = (state_q == BUSY) && !we_q;
  // Write strobe only in the final bus cycle so each store hits memory once.
  assign m_write = (state_q == BUSY) && we_q && (cnt_q == '0);
  assign i_valid = (state_q == DONE) && (src_q == c_src_i);
  assign d_valid = (state_q == DONE) && (src_q == c_src_d);
  assign i_rdata = i_rdata_q;
  assign d_rdata = d_rdata_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ============================================================================
// tb_mem_arbiter
//   Self-checking bench: directed scenarios plus randomized traffic compared
//   against a transaction-timeline reference model.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mem_arbiter;

  localparam int L = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        i_req, d_req, d_we;
  logic [31:0] i_addr, d_addr, d_wdata;
  logic        i_valid, d_valid, m_read, m_write;
  logic [31:0] i_rdata, d_rdata, m_addr, m_din, m_dout;

  logic        l1_i_req, l1_d_req, l1_d_we;
  logic [31:0] l1_i_addr, l1_d_addr, l1_d_wdata;
  logic        l1_i_valid, l1_d_valid, l1_m_read, l1_m_write;
  logic [31:0] l1_i_rdata, l1_d_rdata, l1_m_addr, l1_m_din, l1_m_dout;

  logic [31:0] mem     [0:255];
  logic [31:0] mem1    [0:255];
  logic [31:0] ref_mem [0:255];

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  assign m_dout    = m_read    ? mem[m_addr[9:2]]     : 32'h0;
  assign l1_m_dout = l1_m_read ? mem1[l1_m_addr[9:2]] : 32'h0;

  mem_arbiter #(.MEM_LATENCY(L)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_valid(i_valid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_valid(d_valid), .d_rdata(d_rdata),
    .m_addr(m_addr), .m_din(m_din), .m_read(m_read), .m_write(m_write),
    .m_dout(m_dout)
  );

  mem_arbiter #(.MEM_LATENCY(1)) dut1 (
    .clk(clk), .reset(reset),
    .i_req(l1_i_req), .i_addr(l1_i_addr), .i_valid(l1_i_valid), .i_rdata(l1_i_rdata),
    .d_req(l1_d_req), .d_we(l1_d_we), .d_addr(l1_d_addr), .d_wdata(l1_d_wdata),
    .d_valid(l1_d_valid), .d_rdata(l1_d_rdata),
    .m_addr(l1_m_addr), .m_din(l1_m_din), .m_read(l1_m_read), .m_write(l1_m_write),
    .m_dout(l1_m_dout)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference model: an access occupies L bus cycles then one completion cycle
  // after the grant edge; elapsed counts cycles since that edge.
  bit          r_busy;
  int          r_el;
  bit          r_port;   // 1 = D
  bit          r_last;
  bit          r_we;
  logic [31:0] r_addr, r_wd, r_ird, r_drd;

  task automatic model_reset();
    r_busy = 0; r_el = 0; r_port = 0; r_last = 0; r_we = 0;
    r_addr = 0; r_wd = 0; r_ird = 0; r_drd = 0;
  endtask

  task automatic model_advance();
    if (reset) begin
      model_reset();
    end else if (!r_busy) begin
      if (i_req || d_req) begin
        r_port = d_req && (!i_req || !r_last);
        r_last = r_port;
        r_addr = r_port ? d_addr : i_addr;
        r_wd   = r_port ? d_wdata : 32'h0;
        r_we   = r_port && d_we;
        r_busy = 1;
        r_el   = 1;
      end
    end else begin
      r_el++;
      if (r_el == L + 1) begin
        if (r_we)        ref_mem[r_addr[9:2]] = r_wd;
        else if (r_port) r_drd = ref_mem[r_addr[9:2]];
        else             r_ird = ref_mem[r_addr[9:2]];
      end
      if (r_el == L + 2) r_busy = 0;
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, "_m_read"},  m_read,  r_busy && r_el <= L && !r_we);
    check({tag, "_m_write"}, m_write, r_busy && r_el == L && r_we);
    check({tag, "_i_valid"}, i_valid, r_busy && r_el == L + 1 && !r_port);
    check({tag, "_d_valid"}, d_valid, r_busy && r_el == L + 1 && r_port);
    check({tag, "_m_addr"},  m_addr,  r_addr);
    check({tag, "_m_din"},   m_din,   r_wd);
    check({tag, "_i_rdata"}, i_rdata, r_ird);
    check({tag, "_d_rdata"}, d_rdata, r_drd);
  endtask

  task automatic step();
    @(negedge clk);
    if (m_write)    mem[m_addr[9:2]]     = m_din;
    if (l1_m_write) mem1[l1_m_addr[9:2]] = l1_m_din;
    @(posedge clk);
    #1;
    cyc++;
    model_advance();
    compare_all("cyc");
  endtask

  task automatic wait_done(input string tag, input bit port, output int lat,
                           output int nrd, output int wr_at, output int oth);
    lat = -1; nrd = 0; wr_at = -1; oth = 0;
    for (int n = 1; n <= 30; n++) begin
      step();
      if (m_read) nrd++;
      if (m_write) wr_at = n;
      if ((port ? i_valid : d_valid) === 1'b1) oth++;
      if ((port ? d_valid : i_valid) === 1'b1) begin
        lat = n;
        break;
      end
    end
    if (lat < 0) check({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  initial begin
    int lat, nrd, wr_at, oth, n_done, first, prev, cnt;
    int vcyc [4];
    logic [3:0] order;

    i_req = 0; d_req = 0; d_we = 0; i_addr = 0; d_addr = 0; d_wdata = 0;
    l1_i_req = 0; l1_d_req = 0; l1_d_we = 0; l1_i_addr = 0; l1_d_addr = 0; l1_d_wdata = 0;
    for (int i = 0; i < 256; i++) begin
      mem[i]     = 32'h5A000000 ^ (i * 32'h00010203);
      mem1[i]    = 32'hC3000000 ^ (i * 32'h00030507);
    end
    mem[16'h40 >> 2]  = 32'hDEADBEEF;
    mem[16'h200 >> 2] = 32'hAAAA0000;
    mem1[16'h40 >> 2] = 32'hCAFEF00D;
    for (int i = 0; i < 256; i++) ref_mem[i] = mem[i];
    model_reset();

    #2;
    compare_all("rst");
    check("rst_l1_m_read", l1_m_read, 0);
    check("rst_l1_i_valid", l1_i_valid, 0);
    @(posedge clk); #1;
    reset = 0;
    step();

    // Tie out of reset, then continuous requests from both ports
    d_we = 0; i_addr = 32'h10; d_addr = 32'h20; i_req = 1; d_req = 1;
    prev = cyc; n_done = 0; order = 0;
    for (int i = 0; i < 4; i++) vcyc[i] = -1;
    for (int n = 0; n < 60 && n_done < 4; n++) begin
      step();
      if (d_valid || i_valid) begin
        order = {order[2:0], d_valid};
        vcyc[n_done] = cyc - prev;
        n_done++;
        if (d_valid) d_addr = d_addr + 4;
        if (i_valid) i_addr = i_addr + 4;
      end
    end
    i_req = 0; d_req = 0;
    check("fair_count", n_done, 4);
    check("fair_order", {28'h0, order}, 32'hA);
    check("tie_d_cycle", vcyc[0], 5);
    check("tie_i_cycle", vcyc[1], 11);
    check("fair_d2_cycle", vcyc[2], 17);
    step();

    // Lone fetch
    i_addr = 32'h40; i_req = 1;
    wait_done("fetch", 1'b0, lat, nrd, wr_at, oth);
    i_req = 0;
    check("fetch_lat", lat, 5);
    check("fetch_nread", nrd, 4);
    check("fetch_no_dvalid", oth, 0);
    check("fetch_rdata", i_rdata, 32'hDEADBEEF);
    step();

    // Store then load
    d_we = 1; d_addr = 32'h100; d_wdata = 32'h12345678; d_req = 1;
    wait_done("store", 1'b1, lat, nrd, wr_at, oth);
    d_req = 0;
    check("store_lat", lat, 5);
    check("store_write_cycle", wr_at, 4);
    check("store_no_read", nrd, 0);
    check("store_mem", mem[32'h100 >> 2], 32'h12345678);
    step();
    d_we = 0; d_req = 1;
    wait_done("load", 1'b1, lat, nrd, wr_at, oth);
    d_req = 0;
    check("load_lat", lat, 5);
    check("load_rdata", d_rdata, 32'h12345678);
    step();

    // Reset in cycle 3 of a store
    d_we = 1; d_addr = 32'h200; d_wdata = 32'h5555FFFF; d_req = 1;
    step(); step(); step();
    reset = 1;
    #1;
    model_reset();
    compare_all("arst");
    check("arst_l1_m_addr", l1_m_addr, 0);
    d_req = 0; d_we = 0;
    step(); step();
    reset = 0;
    step(); step(); step();
    check("arst_mem_kept", mem[32'h200 >> 2], 32'hAAAA0000);
    i_addr = 32'h200; i_req = 1;
    wait_done("arst_fetch", 1'b0, lat, nrd, wr_at, oth);
    i_req = 0;
    check("arst_fetch_lat", lat, 5);
    check("arst_fetch_rdata", i_rdata, 32'hAAAA0000);
    step();

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      step();
      if (i_valid) begin
        i_req  = ($urandom_range(0, 3) != 0);
        i_addr = 32'($urandom_range(0, 255)) << 2;
      end else if (!i_req && $urandom_range(0, 2) == 0) begin
        i_req  = 1;
        i_addr = 32'($urandom_range(0, 255)) << 2;
      end
      if (d_valid || (!d_req && $urandom_range(0, 2) == 0)) begin
        d_req   = d_valid ? ($urandom_range(0, 3) != 0) : 1'b1;
        d_we    = 1'($urandom_range(0, 1));
        d_addr  = 32'($urandom_range(0, 255)) << 2;
        d_wdata = $urandom;
      end
    end
    i_req = 0; d_req = 0;
    for (int n = 0; n < 8; n++) step();

    // Latency-1 instance: single fetch, then back-to-back loads
    l1_i_addr = 32'h40; l1_i_req = 1;
    step();
    check("l1_read_c1", l1_m_read, 1);
    check("l1_ivalid_c1", l1_i_valid, 0);
    step();
    check("l1_read_c2", l1_m_read, 0);
    check("l1_ivalid_c2", l1_i_valid, 1);
    check("l1_irdata", l1_i_rdata, 32'hCAFEF00D);
    l1_i_req = 0;
    step();
    l1_d_we = 0; l1_d_addr = 32'h80; l1_d_req = 1;
    first = -1; prev = -1; cnt = 0;
    for (int n = 1; n <= 12; n++) begin
      step();
      if (l1_d_valid) begin
        if (first < 0) first = n;
        else check("l1_d_gap", n - prev, 3);
        prev = n;
        cnt++;
      end
    end
    l1_d_req = 0;
    check("l1_d_first", first, 2);
    check("l1_d_count", cnt, 4);
    check("l1_drdata", l1_d_rdata, mem1[32'h80 >> 2]);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter that shares one single-ported backing memory between the instruction-fetch port (I) and the load/store port (D) of the CPU. The backing memory is word-addressed internally, has an asynchronous read and a synchronous write, and is modelled as taking MEM_LATENCY cycles per access. The arbiter latches one request at a time, holds the memory bus stable for the full latency, and returns a one-cycle completion pulse to the winning port. Arbitration is round-robin on ties.

## Interface
- MEM_LATENCY, 4, number of cycles the memory bus is held per access (must be ≥1)
- clk  in  1  clock; all state updates on posedge
- reset  in  1  asynchronous, active-high; clears all state immediately
- i_req  in  1  fetch request; held with i_addr until i_valid
- i_addr  in  32  fetch byte address
- i_valid  out  1  one-cycle completion pulse for I
- i_rdata  out  32  fetched word; holds its value until the next I completion
- d_req  in  1  data request; held with d_addr/d_wdata/d_we until d_valid
- d_we  in  1  1 = store, 0 = load
- d_addr  in  32  data byte address
- d_wdata  in  32  store data
- d_valid  out  1  one-cycle completion pulse for D (loads and stores)
- d_rdata  out  32  load data; holds its value until the next D load completion; stores leave it unchanged
- m_addr  out  32  byte address to backing memory
- m_din  out  32  write data to backing memory
- m_read  out  1  read enable to backing memory
- m_write  out  1  write enable to backing memory
- m_dout  in  32  backing memory read data (combinational from m_addr/m_read)

## Operation
- States: IDLE, BUSY, DONE. Latched fields: src (I/D), addr, wdata, we. Also latched: last_grant and a latency counter cnt.
- IDLE → BUSY when any request is present. Grant rule: D only if d_req. I only if i_req. If both, grant the port ≠ last_grant.
  - On the grant edge, latch the winner's address/data/we and set src, set last_grant = winner, and set cnt = MEM_LATENCY−1.
  - I accesses always have we = 0.
- BUSY: m_addr = latched addr and m_din = latched wdata.
  - m_read = ~we for every BUSY cycle.
  - m_write = we only in the BUSY cycle where cnt == 0. Exactly one write edge per store.
  - cnt decrements each cycle. When cnt == 0, the next edge captures m_dout into the src port's rdata register (loads/fetches only) and moves to DONE.
- DONE: assert src port's valid for this cycle only. Next state IDLE unconditionally.
- Outside BUSY: m_read = m_write = 0, and m_addr/m_din drive latched values.
- Requests are only sampled in IDLE. Dropping req during BUSY/DONE does not abort; valid still pulses.
- No port is granted twice while the other is continuously requesting.

## Timing
- Reset values: state IDLE, cnt 0, latched fields 0, last_grant = I (so D wins the first tie), i_valid = d_valid = 0, i_rdata = d_rdata = 0, m_read = m_write = 0, m_addr = m_din = 0.
- Request first seen in IDLE cycle 0:
  - BUSY occupies cycles 1..MEM_LATENCY.
  - valid is high in cycle MEM_LATENCY+1.
  - Earliest next grant edge is at the end of IDLE cycle MEM_LATENCY+2.
  - Throughput is one access per MEM_LATENCY+2 cycles.
- rdata is valid in the DONE cycle and stays stable afterwards until the same port's next load completion.
- Reset mid-operation: all outputs drop to reset values combinationally. A store interrupted before the edge ending its cnt == 0 cycle is not written. No valid is issued for an aborted access.
- Both req rise in the same IDLE cycle: the grant follows last_grant. The loser stays pending and is granted at the first IDLE cycle after the winner's DONE, if still requesting.

## Test plan
- Lone fetch (L=4): memory word at 0x40 = 0xDEADBEEF; i_req, addr 0x40 in cycle 0 → m_read high in cycles 1–4, i_valid only in cycle 5, i_rdata = 0xDEADBEEF, d_valid never asserted.
- Store then load: d_we=1, addr 0x100, data 0x12345678 → m_write high only in cycle 4, d_valid cycle 5, d_rdata unchanged. Follow-up load from 0x100 returns d_rdata = 0x12345678.
- Tie out of reset: i_req and d_req in cycle 0 → D served first, d_valid cycle 5. I granted at the end of IDLE cycle 6, i_valid cycle 11.
- Fairness: both ports request continuously with new addresses after each valid, for 4 transactions → completion order D, I, D, I with no back-to-back same-port grants.
- Reset during store: assert reset in cycle 3 of a store to 0x200 holding 0xAAAA0000 → word stays 0xAAAA0000, no d_valid, all outputs zero while reset is high, and IDLE on release.
- MEM_LATENCY = 1: single fetch → m_read only in cycle 1, i_valid in cycle 2. Back-to-back D loads complete every 3 cycles.
